hps_keys_ctrl: RTL
==================

# hps_keys_ctrl

Debounced, interrupt-capable controller for the HPS push-button inputs, sitting between the raw key pins and the HPS lightweight Avalon-MM bridge. It synchronises and debounces each key, latches press events in a write-1-to-clear edge-capture register, and raises a level interrupt for unmasked events. Firmware reads debounced key state, raw state and pending events through a four-word register map.

## Interface
- `WIDTH`, 2: number of keys.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a new key level (10 ms at 50 MHz); must be ≥2.
- `CNT_W`, 20: debounce counter width; must hold `DEBOUNCE_CYCLES-1`.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; **one clock; reset is synchronous and active-low**.
- `in_port`  in  WIDTH  raw key pins, active-low (0 = pressed), asynchronous to `clk`.
- `address`  in  2  Avalon word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `irq`  out  1  level interrupt, active-high.

## Operation
- Register map:
  - 0: debounced state (RO).
  - 1: interrupt mask (RW).
  - 2: edge capture (R, write-1-to-clear).
  - 3: synchronised raw input (RO).
- Bits at and above `WIDTH` read 0. Writes to addresses 0 and 3 are ignored.
- A write occurs when `chipselect` is 1 and `write_n` is 0. Only `writedata[WIDTH-1:0]` is used.
- Synchroniser:
  - Two flops per key, `sync1` and then `sync2`.
  - Reset value is all ones (keys released).
- Per-key debounce FSM, evaluated on each clock edge:
  - STABLE: `sync2 == stable`. The counter is cleared to 0.
  - COUNTING: `sync2 != stable`.
    - If `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`, and an event is generated.
    - Otherwise `cnt <= cnt+1`.
  - Any cycle with `sync2 == stable` returns the key to STABLE and clears the counter, so a bounce restarts the count.
- Events:
  - A stable 1→0 transition (press) sets the key's edge-capture bit.
  - A release (0→1) does not set it unless the macro described under Configuration is defined.
- Edge-capture update priority per bit: set beats clear. If an event and a W1C write of that bit occur in the same cycle, the bit stays 1.
- Interrupt: `irq <= |(edge & mask)`, registered.
- Reset values:
  - `readdata` = 0, `irq` = 0.
  - `stable`, `sync1`, `sync2` = all ones.
  - counters = 0, mask = 0, edge capture = 0.
- Reset asserted mid-count discards the count. No event is produced.

## Timing
- `readdata` is loaded on every clock edge from the register selected by `address`, regardless of `chipselect`. Read latency is 1 cycle, and reads have no side effects.
- Key-event latency: `in_port` changes before edge k and stays constant afterwards.
  - `sync2` updates at edge k+1.
  - `stable` and the edge bit update at edge k+1+`DEBOUNCE_CYCLES`.
  - `irq` (if the key is unmasked) asserts at edge k+2+`DEBOUNCE_CYCLES`.
- A mask or edge-capture write at edge n takes effect in `irq` at edge n+1.
- W1C of the last pending unmasked bit at edge n deasserts `irq` at edge n+1.
- Reads of address 2 issued the cycle after a W1C return the cleared value.

## Configuration
- `HPS_KEYS_CTRL_BOTH_EDGES_EN`:
  - Defined: both press (1→0) and release (0→1) debounced transitions set the edge-capture bit.
  - Undefined: only presses set it. The release path is not built.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=8` and `WIDTH=2`.
- Reset:
  - Stimulus: hold `reset_n`=0 for 3 cycles with `in_port`=2'b00, then release.
  - Response: `readdata`=0 and `irq`=0 during reset. Address 0 reads 2'b11 until 10 cycles after release, then 2'b00.
- Clean press:
  - Stimulus: mask=2'b01; drive `in_port`=2'b10 before edge k.
  - Response: address 0 reads 2'b10 and address 2 reads 2'b01 from edge k+9. `irq` rises at edge k+10.
- Bounce:
  - Stimulus: toggle `in_port[0]` low for 5 cycles, high for 1 cycle, then low steadily.
  - Response: no state change until 8 consecutive low `sync2` samples. Exactly one edge bit is set.
- Masked key:
  - Stimulus: mask=2'b01; press key 1.
  - Response: edge capture = 2'b10 and `irq` stays 0. Writing mask=2'b11 raises `irq` on the next edge.
- W1C race:
  - Stimulus: write 2'b01 to address 2 on the same edge a new key-0 event fires.
  - Response: bit 0 remains 1 and `irq` stays 1. A later write of 2'b01 clears it, and `irq` falls one cycle after.
- Release edge:
  - Stimulus: release key 0 after a press.
  - Response: with `HPS_KEYS_CTRL_BOTH_EDGES_EN` defined, bit 0 is set again. Without it, edge capture is unchanged.

Source files
------------

// File: rtl/hps_keys_ctrl.sv
// hps_keys_ctrl: debounced, interrupt-capable push-button controller on an
// Avalon-MM slave. Each key passes through a two-flop synchroniser and then a
// per-key debounce FSM. Accepted presses are latched in a W1C edge-capture
// register, and a registered level irq is raised for unmasked events.
//
// Register map (word address):
//   0 debounced state (RO)
//   1 interrupt mask (RW)
//   2 edge capture (W1C)
//   3 synchronised raw input (RO)
//
// Optional feature macro: HPS_KEYS_CTRL_BOTH_EDGES_EN.
//   Defined: releases also set edge capture.
//   Undefined: only presses set it.
//
// Bus handshake: the slave has no wait states. A write happens on any clock
// edge where chipselect=1 and write_n=0. readdata is reloaded on every edge
// from the register selected by address, so read data is valid one cycle
// after the address is presented, and reads never change any state.
//
// Debug: o_dbg_state[i] shows key i's FSM state (0 = STABLE, 1 = COUNTING).
module hps_keys_ctrl #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] o_dbg_state
);

  localparam logic [0:0]       ST_STABLE   = 1'b0;
  localparam logic [0:0]       ST_COUNTING = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic [WIDTH-1:0] w_state;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [WIDTH-1:0] w_rd_sel;
  logic             w_unused_wdata;

  // Only the low WIDTH bits of writedata carry meaning.
  assign w_unused_wdata = ^writedata[31:WIDTH];

  assign w_wr = chipselect & ~write_n;

  // Per-key FSM state: a key is COUNTING whenever its synchronised level
  // disagrees with the accepted level. An event fires on the last count.
  always_comb begin
    w_state = '0;
    w_event = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_state[i] = (r_sync2[i] != r_stable[i]) ? ST_COUNTING : ST_STABLE;
      w_event[i] = (w_state[i] == ST_COUNTING) && (r_cnt[i] == CNT_LAST);
    end
  end

  // Work out which accepted transitions set edge capture (r_sync2 becomes
  // the new stable level, so 0 marks a press).
  always_comb begin
`ifdef HPS_KEYS_CTRL_BOTH_EDGES_EN
    w_set = w_event;
`else
    w_set = w_event & ~r_sync2;
`endif
  end

  // Decode W1C writes to the edge-capture register.
  always_comb begin
    w_clr = '0;
    if (w_wr && (address == 2'd2)) begin
      w_clr = writedata[WIDTH-1:0];
    end
  end

  // Read mux feeding the registered readdata.
  always_comb begin
    w_rd_sel = '0;
    case (address)
      2'd0:    w_rd_sel = r_stable;
      2'd1:    w_rd_sel = r_mask;
      2'd2:    w_rd_sel = r_edge;
      default: w_rd_sel = r_sync2;
    endcase
  end

  // Two-flop synchroniser. Resetting to ones models released keys.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce. Any agreeing sample clears the count, so a bounce restarts it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stable <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_state[i] == ST_STABLE) begin
          r_cnt[i] <= '0;
        end else if (w_event[i]) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Mask register and edge capture. A new event beats a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_edge <= '0;
    end else begin
      if (w_wr && (address == 2'd1)) begin
        r_mask <= writedata[WIDTH-1:0];
      end
      r_edge <= (r_edge & ~w_clr) | w_set;
    end
  end

  // Registered read data and level interrupt.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_readdata <= {{(32-WIDTH){1'b0}}, w_rd_sel};
      r_irq      <= |(r_edge & r_mask);
    end
  end

  assign readdata    = r_readdata;
  assign irq         = r_irq;
  assign o_dbg_state = w_state;

endmodule
